// File: rtl/tlul_traffic_master.sv
// TL-UL traffic generator and response checker.
// Issues a programmed run of Get / PutFullData requests using up to 2**SRC_WIDTH
// source IDs in flight, and checks every D-channel response against what was
// recorded when the matching request was accepted.
module tlul_traffic_master #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SIZE_WIDTH   = 3,
  parameter int SRC_WIDTH    = 2,
  parameter int SINK_WIDTH   = 1,
  parameter int OPCODE_WIDTH = 3,
  parameter int PARAM_WIDTH  = 3,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                      clk_100,
  input  logic                      reset_n,
  input  logic                      start,
  input  logic [CNT_WIDTH-1:0]      cfg_num_txn,
  input  logic [ADDR_WIDTH-1:0]     cfg_base_addr,
  input  logic [ADDR_WIDTH-1:0]     cfg_stride,
  input  logic [1:0]                cfg_mode,
  input  logic [DATA_WIDTH-1:0]     cfg_pattern,
  output logic                      busy,
  output logic                      done,
  output logic [CNT_WIDTH-1:0]      resp_count,
  output logic [CNT_WIDTH-1:0]      err_count,
  output logic                      a_valid,
  input  logic                      a_ready,
  output logic [OPCODE_WIDTH-1:0]   a_opcode,
  output logic [PARAM_WIDTH-1:0]    a_param,
  output logic [SIZE_WIDTH-1:0]     a_size,
  output logic [SRC_WIDTH-1:0]      a_source,
  output logic [ADDR_WIDTH-1:0]     a_address,
  output logic [DATA_WIDTH/8-1:0]   a_mask,
  output logic [DATA_WIDTH-1:0]     a_data,
  input  logic                      d_valid,
  output logic                      d_ready,
  input  logic [OPCODE_WIDTH-1:0]   d_opcode,
  input  logic [PARAM_WIDTH-1:0]    d_param,
  input  logic [SIZE_WIDTH-1:0]     d_size,
  input  logic [SRC_WIDTH-1:0]      d_source,
  input  logic [SINK_WIDTH-1:0]     d_sink,
  input  logic [DATA_WIDTH-1:0]     d_data,
  input  logic                      d_error
);

  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int NSRC       = 1 << SRC_WIDTH;
  localparam logic [OPCODE_WIDTH-1:0] OP_PUT  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_GET  = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACK  = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_ACKD = OPCODE_WIDTH'(1);
  localparam logic [1:0] MODE_PAIR = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                          state_q, state_d;
  logic [CNT_WIDTH-1:0]            num_q, num_d, idx_q, idx_d, k_q, k_d;
  logic [CNT_WIDTH-1:0]            resp_q, resp_d, err_q, err_d;
  logic [ADDR_WIDTH-1:0]           addr_q, addr_d, stride_q, stride_d;
  logic [1:0]                      mode_q, mode_d;
  logic [DATA_WIDTH-1:0]           pat_q, pat_d;
  // Per-source table: free flag, Get flag, data-check enable, expected read data
  logic [NSRC-1:0]                 free_q, free_d, get_q, get_d, chk_q, chk_d;
  logic [NSRC-1:0][DATA_WIDTH-1:0] exp_q, exp_d;
  // Mode-10 pair interlock: Put of the current pair not yet acknowledged
  logic                            pw_q, pw_d;
  logic [SRC_WIDTH-1:0]            pw_src_q, pw_src_d;
  // Registered A channel
  logic                            av_q, av_d;
  logic [OPCODE_WIDTH-1:0]         aop_q, aop_d;
  logic [SIZE_WIDTH-1:0]           asize_q, asize_d;
  logic [SRC_WIDTH-1:0]            asrc_q, asrc_d;
  logic [ADDR_WIDTH-1:0]           aaddr_q, aaddr_d;
  logic [MASK_WIDTH-1:0]           amask_q, amask_d;
  logic [DATA_WIDTH-1:0]           adata_q, adata_d;

  logic                            a_hs, start_acc, d_bad, req_get, sel_found;
  logic [SRC_WIDTH-1:0]            sel_src;
  logic [NSRC-1:0]                 hs_mask, avail;
  logic                            unused_d;

  assign a_hs      = av_q & a_ready;
  assign start_acc = start & ((state_q == IDLE) | (state_q == DONE));
  // The ID being handed over this cycle is no longer a candidate for the next request
  assign hs_mask   = a_hs ? (NSRC'(1) << asrc_q) : '0;
  assign avail     = free_q & ~hs_mask;
  assign unused_d  = ^{d_param, d_size, d_sink};

  // Lowest-numbered free source ID
  always_comb begin
    sel_found = 1'b0;
    sel_src   = '0;
    for (int s = 0; s < NSRC; s++) begin
      if (!sel_found && avail[s]) begin
        sel_found = 1'b1;
        sel_src   = SRC_WIDTH'(s);
      end
    end
  end

  // Next-state: response checking, request issue, run control
  always_comb begin
    state_d  = state_q;
    num_d    = num_q;
    idx_d    = idx_q;
    k_d      = k_q;
    resp_d   = resp_q;
    err_d    = err_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    mode_d   = mode_q;
    pat_d    = pat_q;
    free_d   = free_q;
    get_d    = get_q;
    chk_d    = chk_q;
    exp_d    = exp_q;
    pw_d     = pw_q;
    pw_src_d = pw_src_q;
    av_d     = av_q;
    aop_d    = aop_q;
    asize_d  = asize_q;
    asrc_d   = asrc_q;
    aaddr_d  = aaddr_q;
    amask_d  = amask_q;
    adata_d  = adata_q;
    d_bad    = 1'b0;
    req_get  = 1'b0;

    if (start_acc) begin
      resp_d = '0;
      err_d  = '0;
    end

    // D channel: always accepted; at most one error per response
    if (d_valid) begin
      if (resp_d != '1) resp_d = resp_d + CNT_WIDTH'(1);
      if (free_q[d_source]) begin
        d_bad = 1'b1;
      end else begin
        free_d[d_source] = 1'b1;
        if (get_q[d_source]) begin
          if (d_opcode != OP_ACKD) d_bad = 1'b1;
          if (chk_q[d_source] && (d_data != exp_q[d_source])) d_bad = 1'b1;
        end else if (d_opcode != OP_ACK) begin
          d_bad = 1'b1;
        end
        if (pw_q && (pw_src_q == d_source)) pw_d = 1'b0;
      end
      if (d_error) d_bad = 1'b1;
      if (d_bad && (err_d != '1)) err_d = err_d + CNT_WIDTH'(1);
    end

    // A handshake: claim the ID and record what its response must look like
    if (a_hs) begin
      av_d           = 1'b0;
      free_d[asrc_q] = 1'b0;
      get_d[asrc_q]  = (aop_q == OP_GET);
      chk_d[asrc_q]  = (mode_q == MODE_PAIR) && (aop_q == OP_GET);
      exp_d[asrc_q]  = pat_q ^ DATA_WIDTH'(k_q);
      if ((mode_q == MODE_PAIR) && (aop_q == OP_PUT)) begin
        pw_d     = 1'b1;
        pw_src_d = asrc_q;
      end
      idx_d = idx_q + CNT_WIDTH'(1);
      // Pairs share one address step; it advances after the Get
      if ((mode_q != MODE_PAIR) || idx_q[0]) begin
        k_d    = k_q + CNT_WIDTH'(1);
        addr_d = addr_q + stride_q;
      end
    end

    // Present the next request once the A slot is empty and an ID is free
    req_get = (mode_q == 2'b00) || (mode_q == 2'b11) || ((mode_q == MODE_PAIR) && idx_d[0]);
    if ((state_q == ISSUE) && !av_d && (idx_d != num_q) && sel_found &&
        !((mode_q == MODE_PAIR) && req_get && pw_d)) begin
      av_d    = 1'b1;
      asrc_d  = sel_src;
      aop_d   = req_get ? OP_GET : OP_PUT;
      aaddr_d = addr_d;
      adata_d = req_get ? '0 : (pat_q ^ DATA_WIDTH'(k_d));
      amask_d = '1;
      asize_d = SIZE_WIDTH'($clog2(MASK_WIDTH));
    end

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_d    = cfg_num_txn;
          stride_d = cfg_stride;
          mode_d   = cfg_mode;
          pat_d    = cfg_pattern;
          addr_d   = cfg_base_addr;
          idx_d    = '0;
          k_d      = '0;
          pw_d     = 1'b0;
          state_d  = (cfg_num_txn == '0) ? DONE : ISSUE;
        end
      end
      ISSUE:   if (a_hs && (idx_d == num_q)) state_d = DRAIN;
      DRAIN:   if (&free_q) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      num_q    <= '0;
      idx_q    <= '0;
      k_q      <= '0;
      resp_q   <= '0;
      err_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      mode_q   <= '0;
      pat_q    <= '0;
      free_q   <= '1;
      get_q    <= '0;
      chk_q    <= '0;
      exp_q    <= '0;
      pw_q     <= 1'b0;
      pw_src_q <= '0;
      av_q     <= 1'b0;
      aop_q    <= '0;
      asize_q  <= '0;
      asrc_q   <= '0;
      aaddr_q  <= '0;
      amask_q  <= '0;
      adata_q  <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      resp_q   <= resp_d;
      err_q    <= err_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      mode_q   <= mode_d;
      pat_q    <= pat_d;
      free_q   <= free_d;
      get_q    <= get_d;
      chk_q    <= chk_d;
      exp_q    <= exp_d;
      pw_q     <= pw_d;
      pw_src_q <= pw_src_d;
      av_q     <= av_d;
      aop_q    <= aop_d;
      asize_q  <= asize_d;
      asrc_q   <= asrc_d;
      aaddr_q  <= aaddr_d;
      amask_q  <= amask_d;
      adata_q  <= adata_d;
    end
  end

  assign busy       = (state_q == ISSUE) || (state_q == DRAIN);
  assign done       = (state_q == DONE);
  assign resp_count = resp_q;
  assign err_count  = err_q;
  assign a_valid    = av_q;
  assign a_opcode   = aop_q;
  assign a_param    = '0;
  assign a_size     = asize_q;
  assign a_source   = asrc_q;
  assign a_address  = aaddr_q;
  assign a_mask     = amask_q;
  assign a_data     = adata_q;
  assign d_ready    = 1'b1;

endmodule
